// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file writeback path: widths, the PC
// register index, requester identifiers and the writeback request struct.
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int PC_REG   = 15;
  localparam int NUM_REGS = 16;

  // Writeback requester identity; also the encoding of the round-robin state.
  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter with a hold input.
//   clk, rst_n : clock, async active-low reset
//   req_i[1:0] : request vector, bit SRC_EX / bit SRC_MEM
//   hold_i     : suppresses every grant this cycle
//   gnt_o[1:0] : one-hot grant (combinational), zero when nothing granted
// A grant is only ever given to an active request, so any grant is a
// transfer and moves the round-robin pointer.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       hold_i,
  output logic [1:0] gnt_o
);

  src_e last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (!hold_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // contest: whoever did not win last time
        2'b11:   gnt_o = (last_q == SRC_EX) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_EX;
    end else if (|gnt_o) begin
      last_q <= gnt_o[SRC_MEM] ? SRC_MEM : SRC_EX;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the EX and MEM
// writeback requesters, and tracks pending writes for decode hazard stalls.
//   clk, rst_n                      : clock, async active-low reset
//   ex_valid/ex_ready/ex_addr/ex_data     : EX writeback handshake
//   mem_valid/mem_ready/mem_addr/mem_data : MEM writeback handshake
//   hold                            : blocks all grants this cycle
//   rsv_valid/rsv_addr              : decode reserves a destination register
//   rf_wrEn/rf_wrAddr/rf_wrData     : registered register-file write port
//   busy_mask                       : bit i set = write to register i pending
//   err_pc                          : one-cycle pulse after an accepted PC write
// The register file commits on the falling edge, so a write registered at
// rising edge N is visible to readers after the falling edge of cycle N.
module regfile_wb_arbiter #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int PC_REG = regfile_pkg::PC_REG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_W-1:0]     ex_addr,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  hold,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rf_wrEn,
  output logic [ADDR_W-1:0]     rf_wrAddr,
  output logic [DATA_W-1:0]     rf_wrData,
  output logic [(1<<ADDR_W)-1:0] busy_mask,
  output logic                  err_pc
);

  import regfile_pkg::*;

  localparam int                NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_REG);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [1:0]       gnt;
  req_t             sel;
  logic             xfer;
  logic             is_pc;
  logic             wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic             err_q;
  logic [NREGS-1:0] busy_q, busy_d;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  ({mem_valid, ex_valid}),
    .hold_i (hold),
    .gnt_o  (gnt)
  );

  // Grants only go to active requests, so ready doubles as the transfer strobe.
  assign ex_ready  = gnt[SRC_EX];
  assign mem_ready = gnt[SRC_MEM];
  assign xfer      = |gnt;

  always_comb begin
    sel = gnt[SRC_MEM] ? req_t'{addr: mem_addr, data: mem_data}
                       : req_t'{addr: ex_addr,  data: ex_data};
  end

  // PC writes are accepted (and count for round-robin) but never reach the port.
  assign is_pc = (sel.addr == PC_A);

  // Clear for the winning write first, then reservation, so a same-cycle
  // reserve of the same register keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (xfer && !is_pc)               busy_d[sel.addr] = 1'b0;
    if (rsv_valid && rsv_addr != PC_A) busy_d[rsv_addr] = 1'b1;
    busy_d[PC_A] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      busy_q <= '0;
    end else begin
      wren_q <= xfer && !is_pc;
      err_q  <= xfer && is_pc;
      busy_q <= busy_d;
      // Address/data only move on a real write; idle cycles hold them.
      if (xfer && !is_pc) begin
        addr_q <= sel.addr;
        data_q <= sel.data;
      end
    end
  end

  // The async reset clears wren_q immediately, so no write survives into a
  // falling edge while rst_n is low.
  assign rf_wrEn   = wren_q;
  assign rf_wrAddr = addr_q;
  assign rf_wrData = data_q;
  assign busy_mask = busy_q;
  assign err_pc    = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, mem_valid, hold, rsv_valid;
  logic [3:0]  ex_addr, mem_addr, rsv_addr;
  logic [31:0] ex_data, mem_data;
  logic        ex_ready, mem_ready, rf_wrEn, err_pc;
  logic [3:0]  rf_wrAddr;
  logic [31:0] rf_wrData;
  logic [15:0] busy_mask;

  int vec = 0;
  int err = 0;

  // Reference model state
  int          m_last;      // 0 = EX won last, 1 = MEM won last
  logic        m_wren, m_err;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .hold(hold), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rf_wrEn(rf_wrEn), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
    .busy_mask(busy_mask), .err_pc(err_pc)
  );

  task automatic model_reset();
    m_last = 0; m_wren = 0; m_err = 0; m_addr = 0; m_data = 0; m_busy = 0;
  endtask

  // {mem_granted, ex_granted} from the arbitration rules
  function automatic logic [1:0] exp_grant();
    if (hold) return 2'b00;
    if (ex_valid && mem_valid) return (m_last == 0) ? 2'b10 : 2'b01;
    if (ex_valid) return 2'b01;
    if (mem_valid) return 2'b10;
    return 2'b00;
  endfunction

  // One rising edge with the model advanced alongside
  task automatic tick();
    logic [1:0] g;
    logic [3:0] a;
    logic [31:0] d;
    g = exp_grant();
    a = g[1] ? mem_addr : ex_addr;
    d = g[1] ? mem_data : ex_data;
    @(posedge clk);
    if (g != 2'b00) begin
      m_last = g[1] ? 1 : 0;
      if (a == 4'd15) begin
        m_wren = 0; m_err = 1;
      end else begin
        m_wren = 1; m_err = 0; m_addr = a; m_data = d;
        m_busy[a] = 1'b0;
      end
    end else begin
      m_wren = 0; m_err = 0;
    end
    if (rsv_valid && rsv_addr != 4'd15) m_busy[rsv_addr] = 1'b1;
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; mem_valid = 0; hold = 0; rsv_valid = 0;
  endtask

  task automatic test_reset();
    // build some non-zero state first
    idle(); ex_valid = 1; ex_addr = 4; ex_data = 32'h1234_5678;
    rsv_valid = 1; rsv_addr = 7;
    tick();
    // reset mid-cycle with everything active
    ex_valid = 1; mem_valid = 1; rsv_valid = 1; hold = 0;
    ex_addr = 1; mem_addr = 2; rsv_addr = 3;
    #2 rst_n = 0;
    #1;
    vec++; if (rf_wrEn !== 1'b0) begin err++; $display("FAIL reset_wren got %b want 0", rf_wrEn); end
    vec++; if (rf_wrAddr !== 4'd0) begin err++; $display("FAIL reset_addr got %0d want 0", rf_wrAddr); end
    vec++; if (rf_wrData !== 32'd0) begin err++; $display("FAIL reset_data got %h want 0", rf_wrData); end
    vec++; if (busy_mask !== 16'd0) begin err++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    vec++; if (err_pc !== 1'b0) begin err++; $display("FAIL reset_err got %b want 0", err_pc); end
    @(posedge clk); #1;
    vec++; if (rf_wrEn !== 1'b0) begin err++; $display("FAIL reset_hold_wren got %b want 0", rf_wrEn); end
    rst_n = 1;
    model_reset();
    #1;
    vec++; if (mem_ready !== 1'b1 || ex_ready !== 1'b0)
      begin err++; $display("FAIL first_tie got ex=%b mem=%b want ex=0 mem=1", ex_ready, mem_ready); end
    rsv_valid = 0;
    tick();
    vec++; if (rf_wrEn !== 1'b1 || rf_wrAddr !== 4'd2)
      begin err++; $display("FAIL first_tie_write got en=%b addr=%0d want en=1 addr=2", rf_wrEn, rf_wrAddr); end
  endtask

  task automatic test_alternate();
    logic [3:0] want;
    // EX-only write so EX is the last winner
    idle(); ex_valid = 1; ex_addr = 1; ex_data = 32'h11;
    tick();
    mem_valid = 1; mem_addr = 2; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++; if (mem_ready !== (i % 2 == 0) || ex_ready !== (i % 2 == 1))
        begin err++; $display("FAIL alt_ready[%0d] got ex=%b mem=%b", i, ex_ready, mem_ready); end
      tick();
      want = (i % 2 == 0) ? 4'd2 : 4'd1;
      vec++; if (rf_wrEn !== 1'b1 || rf_wrAddr !== want || rf_wrData !== {28'd0, want, want})
        begin err++; $display("FAIL alt_write[%0d] got en=%b addr=%0d data=%h want addr=%0d", i, rf_wrEn, rf_wrAddr, rf_wrData, want); end
    end
  endtask

  task automatic test_hold();
    idle(); hold = 1; ex_valid = 1; ex_addr = 3; ex_data = 32'hDEADBEEF;
    #1;
    vec++; if (ex_ready !== 1'b0) begin err++; $display("FAIL hold_ready got %b want 0", ex_ready); end
    tick();
    vec++; if (rf_wrEn !== 1'b0) begin err++; $display("FAIL hold_wren got %b want 0", rf_wrEn); end
    hold = 0;
    #1;
    vec++; if (ex_ready !== 1'b1) begin err++; $display("FAIL hold_release_ready got %b want 1", ex_ready); end
    tick();
    vec++; if (rf_wrEn !== 1'b1 || rf_wrAddr !== 4'd3 || rf_wrData !== 32'hDEADBEEF)
      begin err++; $display("FAIL hold_release_write got en=%b addr=%0d data=%h want 1/3/deadbeef", rf_wrEn, rf_wrAddr, rf_wrData); end
  endtask

  task automatic test_pc();
    idle(); mem_valid = 1; mem_addr = 15; mem_data = 32'hBAD;
    #1;
    vec++; if (mem_ready !== 1'b1) begin err++; $display("FAIL pc_ready got %b want 1", mem_ready); end
    tick();
    vec++; if (rf_wrEn !== 1'b0 || err_pc !== 1'b1 || rf_wrAddr !== 4'd3)
      begin err++; $display("FAIL pc_reject got en=%b err=%b addr=%0d want 0/1/3", rf_wrEn, err_pc, rf_wrAddr); end
    idle();
    tick();
    vec++; if (err_pc !== 1'b0) begin err++; $display("FAIL pc_pulse got %b want 0", err_pc); end
    // MEM took the PC transfer, so EX wins the next contest
    ex_valid = 1; mem_valid = 1; ex_addr = 6; mem_addr = 8;
    #1;
    vec++; if (ex_ready !== 1'b1 || mem_ready !== 1'b0)
      begin err++; $display("FAIL pc_rr got ex=%b mem=%b want ex=1 mem=0", ex_ready, mem_ready); end
    tick();
    idle(); mem_valid = 1; mem_addr = 8; tick(); idle(); tick();
  endtask

  task automatic test_busy();
    idle(); rsv_valid = 1; rsv_addr = 5;
    tick();
    rsv_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      vec++; if (busy_mask !== 16'h0020) begin err++; $display("FAIL busy_c%0d got %h want 0020", c, busy_mask); end
      if (c == 3) begin ex_valid = 1; ex_addr = 5; ex_data = 32'h55; end
      tick();
    end
    vec++; if (busy_mask !== 16'h0000 || rf_wrEn !== 1'b1)
      begin err++; $display("FAIL busy_clear got mask=%h en=%b want 0000/1", busy_mask, rf_wrEn); end
  endtask

  task automatic test_same_cycle();
    idle(); rsv_valid = 1; rsv_addr = 5;
    tick();
    ex_valid = 1; ex_addr = 5; ex_data = 32'h77; rsv_addr = 5;
    tick();
    vec++; if (busy_mask[5] !== 1'b1) begin err++; $display("FAIL set_wins got %b want 1", busy_mask[5]); end
    idle(); rsv_valid = 1; rsv_addr = 15;
    tick();
    vec++; if (busy_mask !== 16'h0020) begin err++; $display("FAIL rsv_pc got %h want 0020", busy_mask); end
    idle(); ex_valid = 1; ex_addr = 5; tick(); idle(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ex_valid  = ($urandom_range(0, 3) != 0);
      mem_valid = ($urandom_range(0, 3) != 0);
      hold      = ($urandom_range(0, 7) == 0);
      rsv_valid = ($urandom_range(0, 1) == 1);
      ex_addr   = 4'($urandom_range(0, 15));
      mem_addr  = 4'($urandom_range(0, 15));
      rsv_addr  = 4'($urandom_range(0, 15));
      ex_data   = $urandom;
      mem_data  = $urandom;
      #1;
      vec++; if ({mem_ready, ex_ready} !== exp_grant())
        begin err++; $display("FAIL rnd_ready[%0d] got %b%b want %b", i, mem_ready, ex_ready, exp_grant()); end
      tick();
      vec++; if (rf_wrEn !== m_wren || err_pc !== m_err || rf_wrAddr !== m_addr ||
                 rf_wrData !== m_data || busy_mask !== m_busy)
        begin err++; $display("FAIL rnd_out[%0d] got en=%b err=%b a=%0d d=%h busy=%h want en=%b err=%b a=%0d d=%h busy=%h",
                              i, rf_wrEn, err_pc, rf_wrAddr, rf_wrData, busy_mask, m_wren, m_err, m_addr, m_data, m_busy); end
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    ex_addr = 0; mem_addr = 0; rsv_addr = 0; ex_data = 0; mem_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_alternate();
    test_hold();
    test_pc();
    test_busy();
    test_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the single register-file write port between two writeback requesters: execute (EX) and memory (MEM).
- Arbitrates round-robin and registers the winning write into the write port.
- Keeps a 16-bit pending-write scoreboard that decode uses for hazard stalls.
- Sits between the EX/MEM pipeline stages and the register file; register 15 (PC) is never written through this block.

## Interface
Parameters:
- ADDR_W, 4, register address width
- DATA_W, 32, register data width
- PC_REG, 15, register index reserved for PC; writes to it are rejected

Ports:
- clk  in  1  single clock; register file writes on its falling edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX writeback request
- ex_ready  out  1  EX request accepted this cycle
- ex_addr  in  ADDR_W  EX destination register
- ex_data  in  DATA_W  EX write data
- mem_valid  in  1  MEM writeback request
- mem_ready  out  1  MEM request accepted this cycle
- mem_addr  in  ADDR_W  MEM destination register
- mem_data  in  DATA_W  MEM write data
- hold  in  1  suppresses all grants this cycle
- rsv_valid  in  1  decode reserves a destination register
- rsv_addr  in  ADDR_W  register being reserved
- rf_wrEn  out  1  register-file write enable
- rf_wrAddr  out  ADDR_W  register-file write address
- rf_wrData  out  DATA_W  register-file write data
- busy_mask  out  16  bit i set = write to register i pending
- err_pc  out  1  one-cycle pulse: a rejected PC_REG write was accepted

## Operation
- Handshake: a transfer happens when valid && ready. Ready is combinational from the valids, hold and the arbiter state. Ready never depends on the opposing ready.
- Grant rules:
  - hold=1: no grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
- last_grant updates only on a transfer. Its reset value is EX, so the first contest goes to MEM.
- A transfer with addr != PC_REG loads the output register with wrEn=1, addr and data.
- A transfer with addr == PC_REG:
  - is accepted (ready=1) and counts as a grant for round-robin;
  - does not write (wrEn=0) and sets err_pc for the next cycle.
- No transfer: the output register's wrEn=0. addr and data hold their previous values.
- Scoreboard:
  - rsv_valid with rsv_addr != PC_REG sets busy[rsv_addr].
  - A transfer to register a (a != PC_REG) clears busy[a].
  - Set and clear of the same bit in the same cycle: set wins.
  - busy[PC_REG] is always 0.
- Requesters may write registers that are not busy. The arbiter performs no hazard check on writes.

## Timing
- Reset (asynchronous, immediate on rst_n low) sets: rf_wrEn=0, rf_wrAddr=0, rf_wrData=0, busy_mask=0, err_pc=0, last_grant=EX.
- Reset mid-write drops the pending write. Any write still visible at the falling edge during reset is suppressed.
- Latency: a transfer on rising edge N produces rf_wrEn=1 during cycle N→N+1. The register file commits at that cycle's falling edge.
- busy bit: clears at edge N, so busy_mask is low while rf_wrEn is high. Data is readable combinationally after the falling edge of that cycle.
- Throughput: one write per cycle. With both requesters continuously valid, grants strictly alternate.
- Same destination from both requesters in one cycle: they are serialized per round-robin. Requesters guarantee ordering upstream.
- err_pc is high for exactly one cycle per rejected transfer.

## Structure
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W, PC_REG, NUM_REGS=16;
  - typedef enum src_e {SRC_EX=0, SRC_MEM=1};
  - typedef struct wb_req_t {addr, data}.
- Sub-module rr_arb2: two-requester round-robin arbiter with last_grant state and a hold input. It outputs a one-hot grant.
- The top level holds the output register, the scoreboard and the err_pc flop.

## Test plan
- Reset with rst_n=0 mid-cycle, all inputs active → all outputs 0 immediately. After release, first tie is granted to MEM.
- Both valid for 4 cycles (EX r1=0x11, MEM r2=0x22, both held) → grants MEM, EX, MEM, EX. rf_wrEn=1 with addr 2,1,2,1 each following cycle.
- hold=1 with ex_valid=1 → ex_ready=0 and rf_wrEn=0 next cycle. On hold release, EX is granted and r3=0xDEADBEEF is written one cycle later.
- mem_valid, mem_addr=15 → mem_ready=1, rf_wrEn=0 next cycle, err_pc=1 for one cycle, last_grant=MEM.
- rsv r5 in cycle 0, then EX write r5 in cycle 3 → busy_mask=0x0020 in cycles 1-3, and 0 from cycle 4 (while rf_wrEn=1).
- Same-cycle rsv r5 and transfer to r5 → busy[5] remains 1. rsv_addr=15 → busy_mask unchanged.
